xy_counter_fsm: RTL and testbench



---
 rtl/xy_counter_fsm.sv | 101 ++++++++++
 tb/tb_xy_counter_fsm.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/xy_counter_fsm.sv
// x/y-commanded up/down/complement counter with wrap-or-saturate bounds and direction tracking.
// Optional XY_GRAY_EN: state output carries the Gray encoding of the count.
module xy_counter_fsm #(
    parameter int unsigned WIDTH   = 2,
    parameter int unsigned MAX_VAL = 3,
    parameter int unsigned WRAP    = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             x,
    input  logic             y,
    output logic [WIDTH-1:0] state,
    output logic             tc_up,
    output logic             tc_dn,
    output logic             err,
    output logic [1:0]       dir,
    output logic             dir_chg
);

    localparam int unsigned CW = WIDTH + 1;
    localparam logic [CW-1:0] MAXC = CW'(MAX_VAL);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } dir_t;

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] state_nxt;
    logic [CW-1:0]    ext;
    logic [CW-1:0]    nxt_ext;
    logic             bound_hit;
    dir_t             dir_q;
    dir_t             dir_nxt;

    // Next count and direction; a saturated/wrapped bound still sets the direction.
    always_comb begin
        ext       = {1'b0, count};
        nxt_ext   = ext;
        bound_hit = 1'b0;
        dir_nxt   = dir_q;
        if (en) begin
            unique case ({x, y})
                2'b00: dir_nxt = IDLE;
                2'b01: begin
                    dir_nxt = UP;
                    if (ext == MAXC) begin
                        bound_hit = 1'b1;
                        nxt_ext   = (WRAP != 0) ? '0 : MAXC;
                    end else begin
                        nxt_ext = ext + CW'(1);
                    end
                end
                2'b10: begin
                    dir_nxt = DOWN;
                    if (ext == '0) begin
                        bound_hit = 1'b1;
                        nxt_ext   = (WRAP != 0) ? MAXC : '0;
                    end else begin
                        nxt_ext = ext - CW'(1);
                    end
                end
                default: nxt_ext = MAXC - ext;
            endcase
        end
        cnt_nxt = nxt_ext[WIDTH-1:0];
`ifdef XY_GRAY_EN
        state_nxt = cnt_nxt ^ (cnt_nxt >> 1);
`else
        state_nxt = cnt_nxt;
`endif
    end

    // Registered count, flags and direction FSM; clear wins asynchronously.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count   <= '0;
            state   <= '0;
            tc_up   <= 1'b0;
            tc_dn   <= 1'b1;
            err     <= 1'b0;
            dir_q   <= IDLE;
            dir_chg <= 1'b0;
        end else begin
            count   <= cnt_nxt;
            state   <= state_nxt;
            tc_up   <= (nxt_ext == MAXC);
            tc_dn   <= (nxt_ext == '0);
            err     <= err | bound_hit;
            dir_q   <= dir_nxt;
            dir_chg <= ((dir_q == UP) && (dir_nxt == DOWN)) ||
                       ((dir_q == DOWN) && (dir_nxt == UP));
        end
    end

    assign dir = dir_q;

endmodule

// File: tb/tb_xy_counter_fsm.sv
// Directed bench for xy_counter_fsm: one wrapping and one saturating instance share stimulus.
`timescale 1ns/1ps
module tb_xy_counter_fsm;

    logic clk = 1'b0;
    logic clear, en, x, y;
    logic [1:0] w_state, s_state, w_dir, s_dir;
    logic w_tcu, w_tcd, w_err, w_chg;
    logic s_tcu, s_tcd, s_err, s_chg;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    xy_counter_fsm #(.WIDTH(2), .MAX_VAL(3), .WRAP(1)) u_wrap (
        .clk(clk), .clear(clear), .en(en), .x(x), .y(y),
        .state(w_state), .tc_up(w_tcu), .tc_dn(w_tcd), .err(w_err),
        .dir(w_dir), .dir_chg(w_chg));

    xy_counter_fsm #(.WIDTH(2), .MAX_VAL(3), .WRAP(0)) u_sat (
        .clk(clk), .clear(clear), .en(en), .x(x), .y(y),
        .state(s_state), .tc_up(s_tcu), .tc_dn(s_tcd), .err(s_err),
        .dir(s_dir), .dir_chg(s_chg));

    function automatic logic [1:0] es(input logic [1:0] b);
`ifdef XY_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // all outputs of the wrapping instance
    task automatic chk_w(input string tag, input logic [1:0] cnt, input logic tcu,
                         input logic tcd, input logic e, input logic [1:0] d, input logic c);
        chk({tag, ".w.state"}, 32'(w_state), 32'(es(cnt)));
        chk({tag, ".w.tc_up"}, 32'(w_tcu), 32'(tcu));
        chk({tag, ".w.tc_dn"}, 32'(w_tcd), 32'(tcd));
        chk({tag, ".w.err"},   32'(w_err), 32'(e));
        chk({tag, ".w.dir"},   32'(w_dir), 32'(d));
        chk({tag, ".w.chg"},   32'(w_chg), 32'(c));
    endtask

    task automatic chk_s(input string tag, input logic [1:0] cnt, input logic tcd,
                         input logic e, input logic [1:0] d, input logic c);
        chk({tag, ".s.state"}, 32'(s_state), 32'(es(cnt)));
        chk({tag, ".s.tc_dn"}, 32'(s_tcd), 32'(tcd));
        chk({tag, ".s.err"},   32'(s_err), 32'(e));
        chk({tag, ".s.dir"},   32'(s_dir), 32'(d));
        chk({tag, ".s.chg"},   32'(s_chg), 32'(c));
    endtask

    task automatic step(input logic e, input logic [1:0] xy);
        en = e;
        {x, y} = xy;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        #1;
        chk_w("clr", 2'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        chk_s("clr", 2'd0, 1'b1, 1'b0, 2'b00, 1'b0);
        #1 clear = 1'b0;
    endtask

    initial begin
        logic [1:0] up_w [5];
        logic [1:0] up_s [5];
        up_w[0] = 2'd1; up_w[1] = 2'd2; up_w[2] = 2'd3; up_w[3] = 2'd0; up_w[4] = 2'd1;
        up_s[0] = 2'd1; up_s[1] = 2'd2; up_s[2] = 2'd3; up_s[3] = 2'd3; up_s[4] = 2'd3;

        clear = 1'b1; en = 1'b0; x = 1'b0; y = 1'b0;
        #12;
        chk_w("rst", 2'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        @(negedge clk) clear = 1'b0;
        @(posedge clk); #1;

        // count to 2, then clear asynchronously mid-cycle
        step(1'b1, 2'b01);
        step(1'b1, 2'b01);
        chk_w("pre", 2'd2, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        #2 pulse_clear();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b01);
            chk_w("hold", 2'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        end

        // up x5: wrap vs saturate at MAX_VAL
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'b01);
            chk_w("up", up_w[i], up_w[i] == 2'd3, up_w[i] == 2'd0, i >= 3, 2'b01, 1'b0);
            chk_s("up", up_s[i], 1'b0, i >= 3, 2'b01, 1'b0);
        end

        // en=0 holds everything
        step(1'b0, 2'b10);
        chk_w("en0", 2'd1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);

        // from count 1, down x3 (reversal pulses on the first down only)
        #2 pulse_clear();
        step(1'b1, 2'b01);
        step(1'b1, 2'b10);
        chk_w("dn0", 2'd0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1);
        chk_s("dn0", 2'd0, 1'b1, 1'b0, 2'b10, 1'b1);
        step(1'b1, 2'b10);
        chk_w("dn1", 2'd3, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        chk_s("dn1", 2'd0, 1'b1, 1'b1, 2'b10, 1'b0);
        step(1'b1, 2'b10);
        chk_w("dn2", 2'd2, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
        chk_s("dn2", 2'd0, 1'b1, 1'b1, 2'b10, 1'b0);

        // DOWN->UP reversal pulse then clears
        step(1'b1, 2'b01);
        chk_w("rev", 2'd3, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1);
        step(1'b1, 2'b01);
        chk_w("rev2", 2'd0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);

        // complement from 1 -> 2, direction unchanged
        #2 pulse_clear();
        step(1'b1, 2'b01);
        step(1'b1, 2'b11);
        chk_w("cpl", 2'd2, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        chk_s("cpl", 2'd2, 1'b0, 1'b0, 2'b01, 1'b0);
        step(1'b1, 2'b11);
        chk_w("cpl2", 2'd1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);

        // up, idle, down: no reversal pulse through IDLE
        step(1'b1, 2'b01);
        chk_w("via_up", 2'd2, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        step(1'b1, 2'b00);
        chk_w("via_idle", 2'd2, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b1, 2'b10);
        chk_w("via_dn", 2'd1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
